// File: rtl/sr_word_capture.sv
// Frames the upstream shift register's parallel output into WIDTH-bit words and queues them
// in a small FIFO drained over valid/ready. Alignment and overflow errors are sticky flags.
module sr_word_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_sync,
    input  logic [WIDTH-1:0]         shift_word,
    input  logic                     clr_flags,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     aligned,
    output logic                     overflow,
    output logic                     sync_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_ALIGNED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              aligned_q, aligned_d;
    logic              overflow_q, overflow_d;
    logic              sync_err_q, sync_err_d;

    logic              push_s;
    logic              resync_s;
    logic              pop_s;
    logic              full_s;
    logic              wr_en_s;
    logic              drop_s;

    // Frame alignment: count shifted bits and decide when a word is complete.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push_s   = 1'b0;
        resync_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && frame_sync) begin
                    state_d = ST_ALIGNED;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_ALIGNED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_FULL) begin
                    // The cycle that completes a word also carries the next frame's first bit.
                    push_s  = 1'b1;
                    cnt_d   = CNT_ONE;
                end else if (frame_sync) begin
                    resync_s = 1'b1;
                    cnt_d    = CNT_ONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output FIFO bookkeeping, next head word and sticky flags.
    always_comb begin
        pop_s   = out_valid_q & out_ready;
        full_s  = (level_q == LVL_FULL);
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;

        mem_d = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = shift_word;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        out_data_d  = mem_d[rd_ptr_d];
        out_valid_d = (level_d != LVL_ZERO);
        aligned_d   = (state_d == ST_ALIGNED);

        // A new error event wins over a clear in the same cycle.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (resync_s) begin
            sync_err_d = 1'b1;
        end else if (clr_flags) begin
            sync_err_d = 1'b0;
        end else begin
            sync_err_d = sync_err_q;
        end
    end

    // State, FIFO storage and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= LVL_ZERO;
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            aligned_q   <= 1'b0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            aligned_q   <= aligned_d;
            overflow_q  <= overflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign fifo_level = level_q;
    assign aligned    = aligned_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_sr_word_capture.sv
// Randomized bench for sr_word_capture: an upstream shift register feeds the DUT and a
// frame/queue reference model predicts every output each cycle.
module tb_sr_word_capture;

    localparam int W = 4;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] shift_word;
    logic         clr_flags = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   fifo_level;
    logic         aligned;
    logic         overflow;
    logic         sync_err;

    logic [W-1:0] sr = '0;
    assign shift_word = sr;

    int total = 0;
    int bad   = 0;

    // Reference model: bits of the current frame, queued words, sticky flags.
    bit           m_aligned = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_fifo[$];
    bit           m_ovf = 1'b0;
    bit           m_serr = 1'b0;

    sr_word_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_sync (frame_sync),
        .shift_word (shift_word),
        .clr_flags  (clr_flags),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .aligned    (aligned),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_aligned = 1'b0;
        m_bits.delete();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_serr = 1'b0;
    endtask

    task automatic start_frame(input bit si);
        m_bits.delete();
        m_bits.push_back(si);
    endtask

    task automatic model_update(input bit en, input bit fs, input bit si, input bit rdy, input bit clr);
        int           old_n;
        bit           pop;
        bit           push;
        bit           set_serr;
        logic [W-1:0] word;
        if (!reset) begin
            model_reset();
            return;
        end
        old_n    = m_fifo.size();
        pop      = (old_n > 0) && rdy;
        push     = 1'b0;
        set_serr = 1'b0;
        word     = '0;
        if (m_aligned && en && m_bits.size() == W) begin
            push = 1'b1;
            foreach (m_bits[i]) word = {word[W-2:0], m_bits[i]};
        end
        if (!en) begin
            m_aligned = 1'b0;
            m_bits.delete();
        end else if (!m_aligned) begin
            if (fs) begin
                m_aligned = 1'b1;
                start_frame(si);
            end
        end else if (m_bits.size() == W) begin
            start_frame(si);
        end else if (fs) begin
            set_serr = 1'b1;
            start_frame(si);
        end else begin
            m_bits.push_back(si);
        end
        if (pop) void'(m_fifo.pop_front());
        if (clr) begin
            m_ovf  = 1'b0;
            m_serr = 1'b0;
        end
        if (push) begin
            if (old_n == D && !pop) m_ovf = 1'b1;
            else m_fifo.push_back(word);
        end
        if (set_serr) m_serr = 1'b1;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
        check_eq("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
        check_eq("aligned", 32'(aligned), 32'(m_aligned));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("sync_err", 32'(sync_err), 32'(m_serr));
        if (m_fifo.size() > 0) check_eq("out_data", 32'(out_data), 32'(m_fifo[0]));
    endtask

    // One clock: check current outputs, drive inputs, then advance model and upstream register.
    task automatic step(input bit en, input bit fs, input bit si, input bit rdy, input bit clr);
        @(negedge clk);
        check_outputs();
        enable     = en;
        frame_sync = fs;
        out_ready  = rdy;
        clr_flags  = clr;
        @(posedge clk);
        #1;
        model_update(en, fs, si, rdy, clr);
        sr = {sr[W-2:0], si};
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_level"}, 32'(fifo_level), 32'd0);
        check_eq({tag, "_aligned"}, 32'(aligned), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_serr"}, 32'(sync_err), 32'd0);
        check_eq({tag, "_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        int rdy_pct;
        model_reset();
        #12;
        check_all_zero("rst");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Idle with enable but no sync: must stay unaligned.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Single frame 1,0,1,1 -> word B visible the cycle after completion.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t1_prepush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_word", 32'(out_data), 32'hB);

        // Two more frames with no consumer: fill, then overflow; head stays the first word.
        repeat (8) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        check_eq("t3_level", 32'(fifo_level), 32'd2);
        check_eq("t3_ovf", 32'(overflow), 32'd1);
        check_eq("t3_head", 32'(out_data), 32'hB);
        step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b1);
        check_eq("t3_clr", 32'(overflow), 32'd0);

        // Full FIFO, word completes while the consumer pops: level holds at two.
        repeat (2) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
        check_eq("t5_level", 32'(fifo_level), 32'd2);
        check_eq("t5_ovf", 32'(overflow), 32'd0);

        // Mid-frame sync: error flagged, alignment kept, realigned frame completes later.
        step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'($urandom_range(1)), 1'b1, 1'b0);
        check_eq("t4_serr", 32'(sync_err), 32'd1);
        check_eq("t4_aligned", 32'(aligned), 32'd1);
        repeat (4) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        check_eq("t6_pre_level", 32'(fifo_level), 32'd1);

        // Asynchronous reset mid-frame with one stored word.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
        check_eq("t6_no_align", 32'(aligned), 32'd0);
        check_eq("t6_no_push", 32'(out_valid), 32'd0);

        // Randomized traffic with varying consumer pressure.
        for (int ph = 0; ph < 12; ph++) begin
            rdy_pct = (ph % 4) * 30;
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(99) >= 2),
                     ($urandom_range(99) < 8),
                     1'($urandom_range(1)),
                     ($urandom_range(99) < rdy_pct),
                     ($urandom_range(99) < 4));
            end
        end
        @(negedge clk);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
